cr_tlvp_rt: RTL and testbench



---
 rtl/cr_tlvp_rt_pkg.sv | 57 +++++
 rtl/cr_tlvp_rt_seq.sv | 35 +++
 rtl/cr_tlvp_rt.sv | 143 ++++++++++++++
 tb/tb_cr_tlvp_rt.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cr_tlvp_rt_pkg.sv
// Shared types for the TLV router stage.
// Holds the TLV word bus, the native TLV type codes, the router FSM states, the
// forced-pass-through type check and the insert-marker builder.
package cr_tlvp_rt_pkg;

  localparam int unsigned NTypes          = 32;
  localparam int unsigned TlvpOrdNumWidth = 4;
  localparam int unsigned TdataW          = 64;

  typedef enum logic [7:0] {
    TlvRqe  = 8'd0,
    TlvGuid = 8'd1,
    TlvCmd  = 8'd2,
    TlvKey  = 8'd3,
    TlvPhd  = 8'd4,
    TlvPfd  = 8'd5,
    TlvData = 8'd6,
    TlvFtr  = 8'd9
  } tlv_types_e;

  typedef struct packed {
    logic                       insert;
    logic [TlvpOrdNumWidth-1:0] ordern;
    logic [7:0]                 typen;
    logic                       sot;
    logic                       eot;
    logic                       tlast;
    logic [7:0]                 tuser;
    logic [TdataW-1:0]          tdata;
  } tlvp_if_bus_t;

  typedef enum logic [1:0] {
    StIdle,
    StPt,
    StUsr
  } rt_state_e;

  // CMD and FTR carry framing the merge stage needs in order; never divert them.
  function automatic logic is_forced_pt(input logic [7:0] typen);
    return (typen == TlvCmd) || (typen == TlvFtr);
  endfunction

  // One-word marker left in the pass-through stream for a diverted TLV.
  function automatic tlvp_if_bus_t build_marker(input tlvp_if_bus_t               w,
                                                input logic [TlvpOrdNumWidth-1:0] seq);
    tlvp_if_bus_t p;
    p            = '0;
    p.insert     = 1'b1;
    p.sot        = 1'b1;
    p.eot        = 1'b1;
    p.tuser[1:0] = 2'b11;
    p.typen      = w.typen;
    p.ordern     = seq;
    return p;
  endfunction

endpackage

// File: rtl/cr_tlvp_rt_seq.sv
// Insert-marker sequence counter.
// Ports: clk/rst_n (sync active-low), inc_i advance by one (wraps), clr_i return to
// zero (wins over inc_i), seq_o current value.
module cr_tlvp_rt_seq #(
  parameter int unsigned OrdW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc_i,
  input  logic            clr_i,
  output logic [OrdW-1:0] seq_o
);

  logic [OrdW-1:0] seq_q, seq_d;

  always_comb begin
    seq_d = seq_q;
    if (clr_i) begin
      seq_d = '0;
    end else if (inc_i) begin
      seq_d = seq_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq_q <= '0;
    end else begin
      seq_q <= seq_d;
    end
  end

  assign seq_o = seq_q;

endmodule

// File: rtl/cr_tlvp_rt.sv
// TLV router: steers each whole TLV to the pass-through or user FIFO, leaving an
// ordered insert marker in the pass-through stream for every diverted TLV.
// Ports: clk, rst_n (sync active-low); tlvp_id_out_valid/tlvp_id_out input words;
// tlv_route_usr per-type route mask (read at sot); pt_ib_full/usr_ib_full FIFO full;
// pt_ib_wr/pt_ib and usr_ib_wr/usr_ib registered FIFO writes; rt_error one-cycle
// error pulse; rt_ovfl_sticky overflow flag held until reset.
module cr_tlvp_rt
  import cr_tlvp_rt_pkg::*;
#(
  parameter int unsigned N_TYPES = NTypes,
  parameter int unsigned ORD_W   = TlvpOrdNumWidth  // must equal the bus ordern width
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tlvp_id_out_valid,
  input  tlvp_if_bus_t       tlvp_id_out,
  input  logic [N_TYPES-1:0] tlv_route_usr,
  input  logic               pt_ib_full,
  input  logic               usr_ib_full,
  output logic               pt_ib_wr,
  output tlvp_if_bus_t       pt_ib,
  output logic               usr_ib_wr,
  output tlvp_if_bus_t       usr_ib,
  output logic               rt_error,
  output logic               rt_ovfl_sticky
);

  rt_state_e    state_q, state_d;
  logic [ORD_W-1:0] ord_q, ord_d;
  logic [ORD_W-1:0] seq;
  logic         seq_inc, seq_clr;
  logic         sot_in, cont_in, route_usr, in_err, ovfl;
  logic         pt_wr_q, pt_wr_d, usr_wr_q, usr_wr_d, err_q, err_d, sticky_q;
  tlvp_if_bus_t pt_q, pt_d, usr_q, usr_d;

  // A sot is always treated as a fresh TLV, whatever state we are in.
  assign sot_in    = tlvp_id_out_valid & tlvp_id_out.sot;
  assign cont_in   = tlvp_id_out_valid & ~tlvp_id_out.sot & (state_q != StIdle);
  assign route_usr = tlv_route_usr[tlvp_id_out.typen[4:0]] & ~is_forced_pt(tlvp_id_out.typen);

  cr_tlvp_rt_seq #(
    .OrdW(ORD_W)
  ) u_seq (
    .clk  (clk),
    .rst_n(rst_n),
    .inc_i(seq_inc),
    .clr_i(seq_clr),
    .seq_o(seq)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ord_q   <= '0;
    end else begin
      state_q <= state_d;
      ord_q   <= ord_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ord_d   = ord_q;
    if (sot_in) begin
      if (tlvp_id_out.eot) begin
        state_d = StIdle;
      end else begin
        state_d = route_usr ? StUsr : StPt;
      end
      // Body words of a user TLV carry the number its insert marker took.
      if (route_usr) begin
        ord_d = seq;
      end
    end else if (cont_in && tlvp_id_out.eot) begin
      state_d = StIdle;
    end
  end

  always_comb begin
    pt_wr_d  = 1'b0;
    usr_wr_d = 1'b0;
    pt_d     = '0;
    usr_d    = '0;
    seq_inc  = 1'b0;
    in_err   = 1'b0;
    if (tlvp_id_out_valid) begin
      in_err = tlvp_id_out.sot ? (state_q != StIdle) : (state_q == StIdle);
    end
    if (sot_in) begin
      pt_wr_d = 1'b1;
      if (route_usr) begin
        usr_wr_d     = 1'b1;
        usr_d        = tlvp_id_out;
        usr_d.ordern = seq;
        usr_d.insert = 1'b0;
        pt_d         = build_marker(tlvp_id_out, seq);
        seq_inc      = 1'b1;
      end else begin
        pt_d = tlvp_id_out;
      end
    end else if (cont_in) begin
      if (state_q == StUsr) begin
        usr_wr_d     = 1'b1;
        usr_d        = tlvp_id_out;
        usr_d.ordern = ord_q;
        usr_d.insert = 1'b0;
      end else begin
        pt_wr_d = 1'b1;
        pt_d    = tlvp_id_out;
      end
    end
    seq_clr = (sot_in | cont_in) & tlvp_id_out.tlast;
    // Overflow is judged when the registered write actually lands on the FIFO.
    ovfl    = (pt_wr_q & pt_ib_full) | (usr_wr_q & usr_ib_full);
    err_d   = in_err | ovfl;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pt_wr_q  <= 1'b0;
      usr_wr_q <= 1'b0;
      pt_q     <= '0;
      usr_q    <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      pt_wr_q  <= pt_wr_d;
      usr_wr_q <= usr_wr_d;
      pt_q     <= pt_d;
      usr_q    <= usr_d;
      err_q    <= err_d;
      sticky_q <= sticky_q | ovfl;
    end
  end

  assign pt_ib_wr       = pt_wr_q;
  assign pt_ib          = pt_q;
  assign usr_ib_wr      = usr_wr_q;
  assign usr_ib         = usr_q;
  assign rt_error       = err_q;
  assign rt_ovfl_sticky = sticky_q;

endmodule

// File: tb/tb_cr_tlvp_rt.sv
module tb_cr_tlvp_rt;
  import cr_tlvp_rt_pkg::*;

  localparam int SeqMod = 1 << TlvpOrdNumWidth;

  logic         clk = 1'b0;
  logic         rst_n, valid, pf, uf;
  tlvp_if_bus_t din, pt_ib, usr_ib;
  logic [31:0]  mask;
  logic         pt_ib_wr, usr_ib_wr, rt_error, rt_ovfl_sticky;

  always #5 clk = ~clk;

  cr_tlvp_rt dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .tlvp_id_out_valid(valid),
    .tlvp_id_out      (din),
    .tlv_route_usr    (mask),
    .pt_ib_full       (pf),
    .usr_ib_full      (uf),
    .pt_ib_wr         (pt_ib_wr),
    .pt_ib            (pt_ib),
    .usr_ib_wr        (usr_ib_wr),
    .usr_ib           (usr_ib),
    .rt_error         (rt_error),
    .rt_ovfl_sticky   (rt_ovfl_sticky)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model: "inside a TLV" flag, its destination, running and latched order.
  bit m_in, m_usr;
  int m_seq, m_ord;
  logic e_pt_wr, e_usr_wr, e_err, e_sticky;
  tlvp_if_bus_t e_pt, e_usr;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic drive(input logic v, input logic [7:0] t, input logic s, input logic e,
                       input logic l, input logic ins);
    valid     = v;
    din.typen = t;
    din.sot   = s;
    din.eot   = e;
    din.tlast = l;
    din.insert = ins;
    din.tuser = 8'($urandom);
    din.ordern = TlvpOrdNumWidth'($urandom);
    din.tdata = {$urandom, $urandom};
  endtask

  // Called at a negedge with inputs set: predicts the next registered outputs, clocks, compares.
  task automatic step();
    logic ovfl, in_err, usr;
    tlvp_if_bus_t w;
    w = din;
    ovfl = (e_pt_wr && pf) || (e_usr_wr && uf);
    e_pt_wr = 0; e_usr_wr = 0; e_pt = '0; e_usr = '0; in_err = 0;
    if (!rst_n) begin
      m_in = 0; m_seq = 0; e_err = 0; e_sticky = 0;
    end else begin
      if (valid) begin
        if (w.sot) begin
          in_err = m_in;
          usr = mask[w.typen[4:0]] && (w.typen != TlvCmd) && (w.typen != TlvFtr);
          e_pt_wr = 1;
          if (usr) begin
            e_usr = w;
            e_usr.ordern = TlvpOrdNumWidth'(m_seq);
            e_usr.insert = 0;
            e_usr_wr = 1;
            e_pt.insert = 1; e_pt.sot = 1; e_pt.eot = 1; e_pt.tuser = 8'h03;
            e_pt.typen = w.typen;
            e_pt.ordern = TlvpOrdNumWidth'(m_seq);
            m_ord = m_seq;
            m_seq = (m_seq + 1) % SeqMod;
          end else begin
            e_pt = w;
          end
          m_in = !w.eot;
          m_usr = usr;
          if (w.tlast) m_seq = 0;
        end else if (!m_in) begin
          in_err = 1;
        end else begin
          if (m_usr) begin
            e_usr = w;
            e_usr.ordern = TlvpOrdNumWidth'(m_ord);
            e_usr.insert = 0;
            e_usr_wr = 1;
          end else begin
            e_pt = w;
            e_pt_wr = 1;
          end
          if (w.eot) m_in = 0;
          if (w.tlast) m_seq = 0;
        end
      end
      e_err = in_err | ovfl;
      e_sticky = e_sticky | ovfl;
    end
    @(posedge clk);
    #1;
    chk("pt_ib_wr", 128'(pt_ib_wr), 128'(e_pt_wr));
    chk("usr_ib_wr", 128'(usr_ib_wr), 128'(e_usr_wr));
    chk("pt_ib", 128'(pt_ib), 128'(e_pt));
    chk("usr_ib", 128'(usr_ib), 128'(e_usr));
    chk("rt_error", 128'(rt_error), 128'(e_err));
    chk("rt_ovfl_sticky", 128'(rt_ovfl_sticky), 128'(e_sticky));
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 8'd0, 0, 0, 0, 0);
    step();
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    idle();
    rst_n = 1;
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  t;
    logic        sot, eot, tlast;
    logic [31:0] mask;
    logic        pt_wr, usr_wr, pt_ins;
    int          ord;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst_n = 0; valid = 0; din = '0; mask = '0; pf = 0; uf = 0;
    e_pt_wr = 0; e_usr_wr = 0; e_err = 0; e_sticky = 0; e_pt = '0; e_usr = '0;
    m_in = 0; m_usr = 0; m_seq = 0; m_ord = 0;
    @(negedge clk);
    do_reset();
    chk("reset pt_ib_wr", 128'(pt_ib_wr), 128'(0));
    chk("reset usr_ib_wr", 128'(usr_ib_wr), 128'(0));
    chk("reset pt_ib", 128'(pt_ib), 128'(0));
    chk("reset rt_error", 128'(rt_error), 128'(0));
    chk("reset sticky", 128'(rt_ovfl_sticky), 128'(0));

    // Directed table: RQE pass-through, type-5 user TLV, CMD/FTR forced, single-word user.
    vecs.push_back('{1, 8'd0, 1, 0, 0, 32'h0, 1, 0, 0, 0, 0});
    vecs.push_back('{1, 8'd0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0});
    vecs.push_back('{1, 8'd0, 0, 1, 0, 32'h0, 1, 0, 0, 0, 0});
    vecs.push_back('{1, 8'd5, 1, 0, 0, 32'h20, 1, 1, 1, 0, 0});
    vecs.push_back('{1, 8'd5, 0, 0, 0, 32'h20, 0, 1, 0, 0, 0});
    vecs.push_back('{1, 8'd5, 0, 0, 0, 32'h0, 0, 1, 0, 0, 0});
    vecs.push_back('{1, 8'd5, 0, 1, 0, 32'h0, 0, 1, 0, 0, 0});
    vecs.push_back('{1, 8'd2, 1, 1, 0, 32'hffffffff, 1, 0, 0, 0, 0});
    vecs.push_back('{1, 8'd9, 1, 0, 0, 32'hffffffff, 1, 0, 0, 0, 0});
    vecs.push_back('{1, 8'd9, 0, 1, 0, 32'hffffffff, 1, 0, 0, 0, 0});
    vecs.push_back('{1, 8'd5, 1, 1, 0, 32'hffffffff, 1, 1, 1, 1, 0});
    foreach (vecs[i]) begin
      mask = vecs[i].mask;
      drive(vecs[i].v, vecs[i].t, vecs[i].sot, vecs[i].eot, vecs[i].tlast, 0);
      step();
      chk($sformatf("vec%0d pt_wr", i), 128'(pt_ib_wr), 128'(vecs[i].pt_wr));
      chk($sformatf("vec%0d usr_wr", i), 128'(usr_ib_wr), 128'(vecs[i].usr_wr));
      if (vecs[i].pt_wr) chk($sformatf("vec%0d pt insert", i), 128'(pt_ib.insert),
                             128'(vecs[i].pt_ins));
      if (vecs[i].usr_wr) chk($sformatf("vec%0d ordern", i), 128'(usr_ib.ordern),
                              128'(vecs[i].ord));
      chk($sformatf("vec%0d err", i), 128'(rt_error), 128'(vecs[i].err));
    end

    // Sequence wrap, then tlast on a sot clears the counter.
    do_reset();
    mask = 32'hffffffff;
    for (int i = 0; i <= SeqMod; i++) begin
      drive(1, 8'd5, 1, 1, 0, 0);
      step();
      chk($sformatf("wrap ordern %0d", i), 128'(usr_ib.ordern), 128'(i % SeqMod));
    end
    drive(1, 8'd5, 1, 1, 1, 0);
    step();
    chk("tlast tlv ordern", 128'(usr_ib.ordern), 128'(1));
    drive(1, 8'd5, 1, 1, 0, 0);
    step();
    chk("after tlast ordern", 128'(usr_ib.ordern), 128'(0));
    chk("after tlast marker", 128'(pt_ib.ordern), 128'(0));

    // Stray body word in IDLE, then sot inside a PT TLV.
    drive(1, 8'd0, 0, 0, 0, 0);
    step();
    chk("drop err", 128'(rt_error), 128'(1));
    chk("drop no pt", 128'(pt_ib_wr), 128'(0));
    idle();
    chk("drop err clears", 128'(rt_error), 128'(0));
    mask = 32'h20;
    drive(1, 8'd0, 1, 0, 0, 1);
    step();
    chk("pt insert forwarded", 128'(pt_ib.insert), 128'(1));
    drive(1, 8'd5, 1, 0, 0, 0);
    step();
    chk("resot err", 128'(rt_error), 128'(1));
    chk("resot usr", 128'(usr_ib_wr), 128'(1));
    drive(1, 8'd5, 0, 1, 0, 0);
    step();
    chk("resot body usr", 128'(usr_ib_wr), 128'(1));
    chk("resot body err", 128'(rt_error), 128'(0));

    // Overflow on a user write; sticky holds until reset.
    drive(1, 8'd5, 1, 1, 0, 0);
    step();
    uf = 1;
    idle();
    uf = 0;
    chk("ovfl err", 128'(rt_error), 128'(1));
    chk("ovfl sticky", 128'(rt_ovfl_sticky), 128'(1));
    idle();
    idle();
    chk("sticky holds", 128'(rt_ovfl_sticky), 128'(1));
    chk("ovfl err pulse", 128'(rt_error), 128'(0));
    rst_n = 0;
    idle();
    rst_n = 1;
    chk("sticky reset", 128'(rt_ovfl_sticky), 128'(0));

    // Reset mid-TLV: the next body word is an error.
    mask = 32'h0;
    drive(1, 8'd0, 1, 0, 0, 0);
    step();
    rst_n = 0;
    idle();
    rst_n = 1;
    drive(1, 8'd0, 0, 1, 0, 0);
    step();
    chk("post-reset body err", 128'(rt_error), 128'(1));

    // Randomised traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      logic [7:0] t;
      if ($urandom_range(0, 49) == 0) mask = $urandom;
      case ($urandom_range(0, 5))
        0: t = 8'd0;
        1: t = TlvCmd;
        2: t = 8'd5;
        3: t = 8'd6;
        4: t = TlvFtr;
        default: t = 8'($urandom);
      endcase
      drive($urandom_range(0, 9) < 7, t, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4,
            $urandom_range(0, 9) == 0, 1'($urandom));
      pf = $urandom_range(0, 19) == 0;
      uf = $urandom_range(0, 19) == 0;
      rst_n = $urandom_range(0, 199) != 0;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
